// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are committed atomically on the edge that ends the last Busy cycle.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic               accept;
  logic signed [63:0] sa64, sb64, prod_s;
  logic        [63:0] prod_u, div_res;

  // Returns {remainder, quotient}; the signed overflow case is pinned explicitly.
  function automatic logic [63:0] divide(input logic [31:0] n, input logic [31:0] d,
                                         input logic sgn);
    logic signed [31:0] sq, sr;
    if (d == 32'd0) return 64'd0;
    if (sgn) begin
      if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sq = $signed(n) / $signed(d);
      sr = $signed(n) % $signed(d);
      return {sr, sq};
    end
    return {n % d, n / d};
  endfunction

  assign Busy   = (state_q == RUN);
  assign accept = Start && (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU) && (state_q == IDLE);

  assign sa64    = {{32{a_q[31]}}, a_q};
  assign sb64    = {{32{b_q[31]}}, b_q};
  assign prod_s  = sa64 * sb64;
  assign prod_u  = {32'd0, a_q} * {32'd0, b_q};
  assign div_res = divide(a_q, b_q, op_q == OP_DIV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          op_d    = MDUOp;
          a_d     = A;
          b_d     = B;
          cnt_d   = (MDUOp == OP_MULT || MDUOp == OP_MULTU) ? 4'd5 : 4'd10;
        end else if (!Start) begin
          if (MDUOp == OP_MTHI) hi_d = A;
          if (MDUOp == OP_MTLO) lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          // Divide by zero completes silently, leaving HI/LO untouched.
          case (op_q)
            OP_MULT:          {hi_d, lo_d} = prod_s;
            OP_MULTU:         {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU:  if (b_q != 32'd0) {hi_d, lo_d} = div_res;
            default:          ;
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign HI  = hi_q;
  assign LO  = lo_q;
  assign Out = (MDUOp == OP_MFHI) ? hi_q : (MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule
